packet_gen_mp: RTL and testbench



---
 rtl/packet_gen_mp.sv | 239 +++++++++++++++++++++++
 tb/tb_packet_gen_mp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_gen_mp.sv
// Metadata-driven packet generator: a host-filled FIFO of packet descriptors expanded into framed 32-bit word streams.
// Optional build macro PACKET_GEN_STATS_EN adds packet, word and stall counters (stat_pkts, stat_words, stat_stalls).
//
// state   | meaning
// S_IDLE  | waiting for experimenting with metadata queued
// S_LOAD  | FIFO read data captured into the working descriptor
// S_H0    | {byte length, DMAC[47:32]}, start of packet
// S_H1    | DMAC[31:0]
// S_H2    | start_time from the descriptor
// S_H3    | departure timestamp latched at H0 accept
// S_H4    | {16'b0, SMAC[47:32]}
// S_H5    | SMAC[31:0]
// S_PAY   | payload words, last one carries out_eop
module packet_gen_mp #(
  parameter int N_PORTS    = 4,
  parameter int DEPTH      = 1024,
  parameter int META_WIDTH = 32,
  parameter int LEN_W      = 6,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [META_WIDTH-1:0]   meta_in,
  input  logic                    meta_in_en,
  output logic                    meta_in_ready,
  input  logic                    experimenting,
  input  logic [1:0]              payload_mode,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
`ifdef PACKET_GEN_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int PORT_W = $clog2(N_PORTS);
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int TIME_W = META_WIDTH - 2*PORT_W - LEN_W;
  localparam logic [39:0] MAC_OUI = 40'h02_00_00_00_00;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_H0, S_H1, S_H2, S_H3, S_H4, S_H5, S_PAY
  } state_t;

  state_t state_q, state_d;

  logic [META_WIDTH-1:0] mem [DEPTH];
  logic [META_WIDTH-1:0] rd_data_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  full, empty, push, pop, accept;

  logic [META_WIDTH-1:0] work_q;
  logic [31:0]           cyc_q, ts_q, pay_idx_q;
  logic [15:0]           seq_q;
  logic [1:0]            mode_q;

  logic [PORT_W-1:0]     src, dst;
  logic [LEN_W-1:0]      len;
  logic [TIME_W-1:0]     start_time;
  logic [LEN_W:0]        blocks;
  logic [15:0]           byte_len;
  logic [31:0]           last_idx;
  logic                  pay_last;
  logic [47:0]           dmac, smac;
  logic [31:0]           pay_word;

  assign full          = (level_q == LW'(DEPTH));
  assign empty         = (level_q == '0);
  assign push          = meta_in_en && !full;
  assign meta_in_ready = !full;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != S_IDLE);
  assign accept        = out_valid && out_ready;

  // Descriptor fields, most significant first: src, dst, len, start_time
  assign src        = work_q[META_WIDTH-1 -: PORT_W];
  assign dst        = work_q[META_WIDTH-1-PORT_W -: PORT_W];
  assign len        = work_q[META_WIDTH-1-2*PORT_W -: LEN_W];
  assign start_time = work_q[TIME_W-1:0];

  // len==0 encodes the largest packet, 2^LEN_W blocks
  assign blocks   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  assign byte_len = 16'(32'(blocks) * 32'(BLOCK_SIZE));
  assign last_idx = 32'(blocks) * 32'(BLOCK_SIZE / 4) - 32'd7;
  assign pay_last = (pay_idx_q == last_idx);
  assign dmac     = {MAC_OUI, 8'(dst)};
  assign smac     = {MAC_OUI, 8'(src)};

  always_comb begin
    pay_word = '0;
    case (mode_q)
      2'd0:    pay_word = '1;
      2'd1:    pay_word = pay_idx_q;
      2'd2:    pay_word = {8'(src), 8'(dst), seq_q};
      default: pay_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (experimenting && !empty) begin
          state_d = S_LOAD;
          pop     = 1'b1;
        end
      end
      S_LOAD: state_d = S_H0;
      S_H0: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_data  = {byte_len, dmac[47:32]};
        if (out_ready) state_d = S_H1;
      end
      S_H1: begin
        out_valid = 1'b1;
        out_data  = dmac[31:0];
        if (out_ready) state_d = S_H2;
      end
      S_H2: begin
        out_valid = 1'b1;
        out_data  = 32'(start_time);
        if (out_ready) state_d = S_H3;
      end
      S_H3: begin
        out_valid = 1'b1;
        out_data  = ts_q;
        if (out_ready) state_d = S_H4;
      end
      S_H4: begin
        out_valid = 1'b1;
        out_data  = {16'h0000, smac[47:32]};
        if (out_ready) state_d = S_H5;
      end
      S_H5: begin
        out_valid = 1'b1;
        out_data  = smac[31:0];
        if (out_ready) state_d = S_PAY;
      end
      S_PAY: begin
        out_valid = 1'b1;
        out_eop   = pay_last;
        out_data  = pay_word;
        if (out_ready && pay_last) begin
          if (experimenting && !empty) begin
            state_d = S_LOAD;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage kept out of the reset domain so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= meta_in;
    if (pop)  rd_data_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      work_q     <= '0;
      cyc_q      <= '0;
      ts_q       <= '0;
      pay_idx_q  <= '0;
      seq_q      <= '0;
      mode_q     <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_q + 32'd1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (meta_in_en && full) overflow_q <= 1'b1;
      if (state_q == S_LOAD) begin
        work_q    <= rd_data_q;
        pay_idx_q <= '0;
      end
      if (state_q == S_H0 && accept) begin
        ts_q   <= cyc_q;
        mode_q <= payload_mode;
      end
      if (state_q == S_PAY && accept) begin
        pay_idx_q <= pay_idx_q + 32'd1;
        if (pay_last) seq_q <= seq_q + 16'd1;
      end
    end
  end

`ifdef PACKET_GEN_STATS_EN
  logic [31:0] stat_pkts_q, stat_words_q, stat_stalls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pkts_q   <= '0;
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (accept && out_eop)       stat_pkts_q   <= stat_pkts_q + 32'd1;
      if (accept)                  stat_words_q  <= stat_words_q + 32'd1;
      if (out_valid && !out_ready) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_pkts   = stat_pkts_q;
  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_packet_gen_mp.sv
// Scoreboard bench for packet_gen_mp: directed descriptors push expected words, a monitor pops and compares accepted words.
module tb_packet_gen_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] meta_in;
  logic        meta_in_en;
  logic        meta_in_ready;
  logic        experimenting;
  logic [1:0]  payload_mode;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic [10:0] fifo_level;
  logic        overflow;
`ifdef PACKET_GEN_STATS_EN
  logic [31:0] stat_pkts, stat_words, stat_stalls;
`endif

  packet_gen_mp dut (
    .clk(clk), .reset(reset),
    .meta_in(meta_in), .meta_in_en(meta_in_en), .meta_in_ready(meta_in_ready),
    .experimenting(experimenting), .payload_mode(payload_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow)
`ifdef PACKET_GEN_STATS_EN
    , .stat_pkts(stat_pkts), .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic        ts;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          seq = 0;
  logic [31:0] tb_cyc;
  logic [31:0] ts_model = '0;
  int          tb_stalls = 0, tb_words = 0, tb_pkts = 0;

  always @(posedge clk or negedge reset)
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic sop, input logic eop, input logic ts);
    exp_t e;
    e.d = d; e.sop = sop; e.eop = eop; e.ts = ts;
    sb.push_back(e);
  endtask

  // Expected stream for one descriptor with the default geometry: 32-byte blocks, 8 words each
  task automatic exp_pkt(input logic [1:0] s, input logic [1:0] d, input logic [5:0] l,
                         input logic [21:0] t, input logic [1:0] m);
    int          blocks, words;
    logic [31:0] bytes, pw;
    blocks = (l == 6'd0) ? 64 : int'(l);
    words  = blocks * 8;
    bytes  = 32'(blocks * 32);
    push_exp({bytes[15:0], 16'h0200}, 1'b1, 1'b0, 1'b0);
    push_exp({30'd0, d},              1'b0, 1'b0, 1'b0);
    push_exp({10'd0, t},              1'b0, 1'b0, 1'b0);
    push_exp(32'd0,                   1'b0, 1'b0, 1'b1);
    push_exp(32'h0000_0200,           1'b0, 1'b0, 1'b0);
    push_exp({30'd0, s},              1'b0, 1'b0, 1'b0);
    for (int i = 0; i < words - 6; i++) begin
      case (m)
        2'd0:    pw = 32'hFFFF_FFFF;
        2'd1:    pw = 32'(i);
        2'd2:    pw = {6'd0, s, 6'd0, d, 16'(seq)};
        default: pw = 32'h0000_0000;
      endcase
      push_exp(pw, 1'b0, (i == words - 7), 1'b0);
    end
    seq++;
  endtask

  task automatic write_meta(input logic [1:0] s, input logic [1:0] d, input logic [5:0] l,
                            input logic [21:0] t);
    @(negedge clk);
    meta_in    = {s, d, l, t};
    meta_in_en = 1'b1;
    @(negedge clk);
    meta_in_en = 1'b0;
  endtask

  task automatic run(input int budget, input bit toggle);
    int n = 0;
    do begin
      @(negedge clk);
      if (toggle) out_ready = ~out_ready;
      n++;
    end while ((sb.size() != 0 || busy) && n < budget);
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL run_timeout pending=%0d busy=%0d", sb.size(), busy);
      sb.delete();
    end
    out_ready = 1'b1;
  endtask

  // Monitor: samples mid-low-phase, after stimulus settles and before the next edge
  initial begin : monitor
    logic [31:0] prev_d;
    logic [1:0]  prev_f;
    logic        have_prev;
    exp_t        e;
    logic [31:0] exp_d;
    have_prev = 1'b0;
    prev_d    = '0;
    prev_f    = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        have_prev = 1'b0;
        tb_stalls = 0; tb_words = 0; tb_pkts = 0;
      end else if (out_valid) begin
        if (have_prev) begin
          check("hold_data",  out_data, prev_d);
          check("hold_flags", {30'd0, out_sop, out_eop}, {30'd0, prev_f});
        end
        if (out_ready) begin
          have_prev = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", out_data);
          end else begin
            e     = sb.pop_front();
            exp_d = e.ts ? ts_model : e.d;
            check("word_data", out_data, exp_d);
            check("word_sop",  {31'd0, out_sop}, {31'd0, e.sop});
            check("word_eop",  {31'd0, out_eop}, {31'd0, e.eop});
            if (out_sop) ts_model = tb_cyc;
            tb_words++;
            if (out_eop) tb_pkts++;
          end
        end else begin
          have_prev = 1'b1;
          prev_d    = out_data;
          prev_f    = {out_sop, out_eop};
          tb_stalls++;
        end
      end
    end
  end

  initial begin : stim
    int n;
    meta_in       = '0;
    meta_in_en    = 1'b0;
    experimenting = 1'b0;
    payload_mode  = 2'd0;
    out_ready     = 1'b1;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sop_eop",   {30'd0, out_sop, out_eop}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_level",     32'(fifo_level), 32'd0);
    check("rst_overflow",  {31'd0, overflow}, 32'd0);
    check("rst_ready",     {31'd0, meta_in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Basic 1-block packet, all-ones payload
    payload_mode  = 2'd0;
    exp_pkt(2'd1, 2'd2, 6'd1, 22'h5, 2'd0);
    write_meta(2'd1, 2'd2, 6'd1, 22'h5);
    experimenting = 1'b1;
    run(200, 1'b0);

    // len==0: 64 blocks, 512 words, zero payload
    payload_mode = 2'd3;
    exp_pkt(2'd3, 2'd0, 6'd0, 22'h3F_FFFF, 2'd3);
    write_meta(2'd3, 2'd0, 6'd0, 22'h3F_FFFF);
    run(2000, 1'b0);

    // Backpressure every other cycle, index payload
    payload_mode = 2'd1;
    exp_pkt(2'd2, 2'd3, 6'd2, 22'h0_0ABC, 2'd1);
    write_meta(2'd2, 2'd3, 6'd2, 22'h0_0ABC);
    run(500, 1'b1);
`ifdef PACKET_GEN_STATS_EN
    check("stat_stalls", stat_stalls, 32'(tb_stalls));
    check("stat_words",  stat_words,  32'(tb_words));
    check("stat_pkts",   stat_pkts,   32'(tb_pkts));
`endif

    // Back-to-back descriptors, sequence payload
    experimenting = 1'b0;
    payload_mode  = 2'd2;
    write_meta(2'd1, 2'd3, 6'd1, 22'h1);
    write_meta(2'd2, 2'd1, 6'd1, 22'h2);
    check("b2b_level", 32'(fifo_level), 32'd2);
    exp_pkt(2'd1, 2'd3, 6'd1, 22'h1, 2'd2);
    exp_pkt(2'd2, 2'd1, 6'd1, 22'h2, 2'd2);
    experimenting = 1'b1;
    run(200, 1'b0);

    // experimenting dropped at H3 with two queued: only the first completes
    experimenting = 1'b0;
    payload_mode  = 2'd0;
    write_meta(2'd0, 2'd1, 6'd1, 22'h10);
    write_meta(2'd3, 2'd2, 6'd1, 22'h20);
    exp_pkt(2'd0, 2'd1, 6'd1, 22'h10, 2'd0);
    experimenting = 1'b1;
    n = 0;
    while (!(out_valid && out_sop) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drop_sop_seen", {31'd0, out_valid && out_sop}, 32'd1);
    repeat (3) @(negedge clk);
    experimenting = 1'b0;
    run(200, 1'b0);
    repeat (3) @(negedge clk);
    check("drop_busy",  {31'd0, busy}, 32'd0);
    check("drop_level", 32'(fifo_level), 32'd1);
    exp_pkt(2'd3, 2'd2, 6'd1, 22'h20, 2'd0);
    experimenting = 1'b1;
    run(200, 1'b0);

    // Reset in the middle of a long payload
    experimenting = 1'b0;
    write_meta(2'd1, 2'd1, 6'd0, 22'h0);
    write_meta(2'd2, 2'd2, 6'd1, 22'h0);
    exp_pkt(2'd1, 2'd1, 6'd0, 22'h0, 2'd0);
    experimenting = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_busy",  {31'd0, busy}, 32'd1);
    check("mid_level", 32'(fifo_level), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    sb.delete();
    seq = 0;
    experimenting = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Fill the FIFO, then one extra write
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      meta_in    = {2'd0, 2'd0, 6'd1, 22'(i)};
      meta_in_en = 1'b1;
    end
    @(negedge clk);
    meta_in_en = 1'b0;
    check("full_ready",    {31'd0, meta_in_ready}, 32'd0);
    check("full_level",    32'(fifo_level), 32'd1024);
    check("full_overflow", {31'd0, overflow}, 32'd0);
    write_meta(2'd1, 2'd1, 6'd1, 22'h1);
    check("ovf_level",    32'(fifo_level), 32'd1024);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
